// File: rtl/result_write_back.sv
// Write-back stage: commits an execute-stage result to the output register image,
// the bit RAM or the byte RAM (req/ack handshake), and exposes the pending write for bypass.
module result_write_back #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wbValid,
  output logic              wbReady,
  input  logic [1:0]        wbSel,
  input  logic [ADDR_W-1:0] wbAddr,
  input  logic [7:0]        wbData,
  output logic              outWrEn,
  output logic [ADDR_W-1:0] outWrAddr,
  output logic              outWrData,
  output logic              bitWrEn,
  output logic [ADDR_W-1:0] bitWrAddr,
  output logic              bitWrData,
  output logic              byteWrReq,
  output logic [ADDR_W-1:0] byteWrAddr,
  output logic [7:0]        byteWrData,
  input  logic              byteWrAck,
  output logic              fwdValid,
  output logic [1:0]        fwdSel,
  output logic [ADDR_W-1:0] fwdAddr,
  output logic [7:0]        fwdData,
  output logic              wbErr,
  input  logic              errClr
);

  typedef enum logic [0:0] {IDLE, BYTE_WAIT} state_t;

  localparam logic [1:0] SEL_IN   = 2'b00;
  localparam logic [1:0] SEL_OUT  = 2'b01;
  localparam logic [1:0] SEL_BIT  = 2'b10;
  localparam logic [1:0] SEL_BYTE = 2'b11;

  state_t            state_q, state_d;
  logic [1:0]        h_sel_q, h_sel_d;
  logic [ADDR_W-1:0] h_addr_q, h_addr_d;
  logic [7:0]        h_data_q, h_data_d;
  logic              h_valid_q, h_valid_d;
  logic              ready_q, ready_d;
  logic              out_en_q, out_en_d;
  logic              bit_en_q, bit_en_d;
  logic              byte_req_q, byte_req_d;
  logic              err_q, err_d;
  logic              accept;

  always_comb begin
    state_d    = state_q;
    h_sel_d    = h_sel_q;
    h_addr_d   = h_addr_q;
    h_data_d   = h_data_q;
    h_valid_d  = 1'b0;
    out_en_d   = 1'b0;
    bit_en_d   = 1'b0;
    err_d      = err_q;
    accept     = wbValid && ready_q;

    // Holding register captures every accepted write, including dropped ones,
    // but only real destinations count as pending for bypass.
    if (accept) begin
      h_sel_d   = wbSel;
      h_addr_d  = wbAddr;
      h_data_d  = wbData;
      h_valid_d = (wbSel != SEL_IN);
      out_en_d  = (wbSel == SEL_OUT);
      bit_en_d  = (wbSel == SEL_BIT);
    end

    unique case (state_q)
      IDLE: begin
        if (accept && wbSel == SEL_BYTE) state_d = BYTE_WAIT;
      end
      BYTE_WAIT: begin
        if (byteWrAck) state_d = IDLE;
        else           h_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A new error in the same cycle as errClr takes priority.
    if (accept && wbSel == SEL_IN) err_d = 1'b1;
    else if (errClr)               err_d = 1'b0;

    byte_req_d = (state_d == BYTE_WAIT);
    ready_d    = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      h_sel_q    <= '0;
      h_addr_q   <= '0;
      h_data_q   <= '0;
      h_valid_q  <= 1'b0;
      ready_q    <= 1'b0;
      out_en_q   <= 1'b0;
      bit_en_q   <= 1'b0;
      byte_req_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_sel_q    <= h_sel_d;
      h_addr_q   <= h_addr_d;
      h_data_q   <= h_data_d;
      h_valid_q  <= h_valid_d;
      ready_q    <= ready_d;
      out_en_q   <= out_en_d;
      bit_en_q   <= bit_en_d;
      byte_req_q <= byte_req_d;
      err_q      <= err_d;
    end
  end

  assign wbReady    = ready_q;
  assign outWrEn    = out_en_q;
  assign outWrAddr  = h_addr_q;
  assign outWrData  = h_data_q[0];
  assign bitWrEn    = bit_en_q;
  assign bitWrAddr  = h_addr_q;
  assign bitWrData  = h_data_q[0];
  assign byteWrReq  = byte_req_q;
  assign byteWrAddr = h_addr_q;
  assign byteWrData = h_data_q;
  assign fwdValid   = h_valid_q;
  assign fwdSel     = h_sel_q;
  assign fwdAddr    = h_addr_q;
  assign fwdData    = h_data_q;
  assign wbErr      = err_q;

endmodule
